lc3_mem_arbiter: RTL and testbench

Single-port memory arbiter for the LC3 pipeline. It shares one variable-latency unified memory between the fetch stage's instruction reads and the memory-access stage's data reads and writes. It returns per-requester completion pulses (`complete_instr`, `complete_data`) of the form the controller consumes. Data requests have priority, bounded by an anti-starvation counter, and a watchdog aborts memory accesses that hang.

---
 rtl/lc3_mem_arbiter_if.sv | 31 +++
 rtl/lc3_mem_arbiter.sv | 91 +++++++++
 tb/tb_lc3_mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_arbiter_if.sv
// lc3_mem_arbiter_if: requester, memory and status signals of the LC3 memory arbiter
interface lc3_mem_arbiter_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] instr_dout;
  logic        complete_instr;
  logic        dmem_req;
  logic        dmem_rd;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] data_dout;
  logic        complete_data;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_ready;
  logic        busy;
  logic        timeout_err;
  modport slave (
    input  imem_rd, imem_addr, dmem_req, dmem_rd, dmem_addr, dmem_din, mem_dout, mem_ready,
    output instr_dout, complete_instr, data_dout, complete_data, mem_en, mem_we, mem_addr,
           mem_din, busy, timeout_err
  );
  modport master (
    output imem_rd, imem_addr, dmem_req, dmem_rd, dmem_addr, dmem_din, mem_dout, mem_ready,
    input  instr_dout, complete_instr, data_dout, complete_data, mem_en, mem_we, mem_addr,
           mem_din, busy, timeout_err
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one variable-latency memory between instruction fetch and data access
module lc3_mem_arbiter #(
  parameter int DATA_BURST = 4,
  parameter int MAX_WAIT   = 255
) (
  input logic              clk,
  input logic              rst,
  lc3_mem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         state_q;
  logic [3:0]     starve_q;
  logic [WW-1:0]  wait_q;
  logic [WW-1:0]  wait_d;
  logic           own_data_q;
  logic [15:0]    instr_dout_q, data_dout_q, mem_addr_q, mem_din_q;
  logic           mem_en_q, mem_we_q, cmp_i_q, cmp_d_q, busy_q, tmo_q;
  logic           gnt_d, gnt_i, expire;
  logic [15:0]    rdata;
  // data wins unless the pending fetch has already been passed over DATA_BURST times
  assign gnt_d  = bus.dmem_req && !(bus.imem_rd && starve_q == 4'(DATA_BURST));
  assign gnt_i  = bus.imem_rd && !gnt_d;
  assign wait_d = wait_q + 1'b1;
  assign expire = wait_d == WW'(MAX_WAIT);
  assign rdata  = bus.mem_ready ? bus.mem_dout : 16'hFFFF;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      wait_q       <= '0;
      own_data_q   <= 1'b0;
      instr_dout_q <= '0;
      data_dout_q  <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cmp_i_q      <= 1'b0;
      cmp_d_q      <= 1'b0;
      busy_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt_d || gnt_i) begin
          state_q    <= BUSY;
          own_data_q <= gnt_d;
          mem_en_q   <= 1'b1;
          mem_we_q   <= gnt_d && !bus.dmem_rd;
          mem_addr_q <= gnt_d ? bus.dmem_addr : bus.imem_addr;
          mem_din_q  <= (gnt_d && !bus.dmem_rd) ? bus.dmem_din : 16'h0000;
          wait_q     <= '0;
          busy_q     <= 1'b1;
          starve_q   <= (gnt_d && bus.imem_rd) ? starve_q + 4'd1 : 4'd0;
        end
        BUSY: begin
          wait_q <= wait_d;
          if (bus.mem_ready || expire) begin
            state_q    <= DONE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            cmp_d_q    <= own_data_q;
            cmp_i_q    <= !own_data_q;
            if (!bus.mem_ready) tmo_q <= 1'b1;
            if (!own_data_q) instr_dout_q <= rdata;
            else if (!mem_we_q) data_dout_q <= rdata;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cmp_i_q <= 1'b0;
          cmp_d_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.instr_dout     = instr_dout_q;
  assign bus.data_dout      = data_dout_q;
  assign bus.complete_instr = cmp_i_q;
  assign bus.complete_data  = cmp_d_q;
  assign bus.mem_en         = mem_en_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_din        = mem_din_q;
  assign bus.busy           = busy_q;
  assign bus.timeout_err    = tmo_q;
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: directed checks of arbitration, latency, watchdog and reset
module tb_lc3_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [5:0] order;
  lc3_mem_arbiter_if bus();
  lc3_mem_arbiter #(.DATA_BURST(4), .MAX_WAIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.imem_rd = 0; bus.imem_addr = 0; bus.dmem_req = 0; bus.dmem_rd = 0;
    bus.dmem_addr = 0; bus.dmem_din = 0; bus.mem_dout = 0; bus.mem_ready = 0;
    tick; tick;
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_tmo", bus.timeout_err, 1'b0);
    chk16("rst_idout", bus.instr_dout, 16'h0000);
    chk16("rst_ddout", bus.data_dout, 16'h0000);
    rst = 0;
    tick;
    // instruction read, ready in the second BUSY cycle
    bus.imem_rd = 1; bus.imem_addr = 16'h3000;
    chk1("i_idle_en", bus.mem_en, 1'b0);
    tick;
    chk1("i_b1_en", bus.mem_en, 1'b1);
    chk1("i_b1_we", bus.mem_we, 1'b0);
    chk16("i_b1_addr", bus.mem_addr, 16'h3000);
    chk1("i_b1_busy", bus.busy, 1'b1);
    tick;
    chk1("i_b2_en", bus.mem_en, 1'b1);
    chk1("i_b2_cmp", bus.complete_instr, 1'b0);
    bus.mem_ready = 1; bus.mem_dout = 16'h1234;
    tick;
    chk1("i_done_cmp", bus.complete_instr, 1'b1);
    chk1("i_done_cmpd", bus.complete_data, 1'b0);
    chk16("i_done_dout", bus.instr_dout, 16'h1234);
    chk1("i_done_en", bus.mem_en, 1'b0);
    chk16("i_done_addr", bus.mem_addr, 16'h0000);
    chk1("i_done_busy", bus.busy, 1'b1);
    bus.imem_rd = 0; bus.mem_ready = 0;
    tick;
    chk1("i_idle_cmp", bus.complete_instr, 1'b0);
    chk1("i_idle_busy", bus.busy, 1'b0);
    // data read, memory ready immediately
    bus.dmem_req = 1; bus.dmem_rd = 1; bus.dmem_addr = 16'h5000; bus.mem_ready = 1; bus.mem_dout = 16'hABCD;
    tick;
    chk16("dr_addr", bus.mem_addr, 16'h5000);
    chk1("dr_we", bus.mem_we, 1'b0);
    tick;
    chk1("dr_cmp", bus.complete_data, 1'b1);
    chk16("dr_dout", bus.data_dout, 16'hABCD);
    chk16("dr_idout", bus.instr_dout, 16'h1234);
    bus.dmem_req = 0;
    tick;
    // data write leaves data_dout untouched
    bus.dmem_req = 1; bus.dmem_rd = 0; bus.dmem_addr = 16'h4000; bus.dmem_din = 16'hBEEF; bus.mem_dout = 16'h1111;
    tick;
    chk1("dw_we", bus.mem_we, 1'b1);
    chk16("dw_din", bus.mem_din, 16'hBEEF);
    chk16("dw_addr", bus.mem_addr, 16'h4000);
    tick;
    chk1("dw_cmp", bus.complete_data, 1'b1);
    chk1("dw_cmpi", bus.complete_instr, 1'b0);
    chk16("dw_dout", bus.data_dout, 16'hABCD);
    chk1("dw_done_we", bus.mem_we, 1'b0);
    chk16("dw_done_din", bus.mem_din, 16'h0000);
    bus.dmem_req = 0;
    tick;
    // both requesting continuously: D,D,D,D,I,D
    order = 6'b101111;
    bus.imem_rd = 1; bus.imem_addr = 16'h3000;
    bus.dmem_req = 1; bus.dmem_rd = 1; bus.dmem_addr = 16'h4000; bus.mem_ready = 1; bus.mem_dout = 16'h0D00;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk16($sformatf("arb%0d_addr", i), bus.mem_addr, order[i] ? 16'h4000 : 16'h3000);
      tick;
      chk1($sformatf("arb%0d_cmpd", i), bus.complete_data, order[i]);
      chk1($sformatf("arb%0d_cmpi", i), bus.complete_instr, !order[i]);
      if (i == 5) begin
        bus.imem_rd = 0; bus.dmem_req = 0;
      end
      tick;
    end
    bus.mem_ready = 0;
    // ready arrives in the cycle the wait counter hits the limit
    bus.imem_rd = 1; bus.imem_addr = 16'h7000;
    tick;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk1($sformatf("lim_en%0d", i), bus.mem_en, 1'b1);
    end
    bus.mem_ready = 1; bus.mem_dout = 16'h7777;
    tick;
    chk1("lim_cmp", bus.complete_instr, 1'b1);
    chk16("lim_dout", bus.instr_dout, 16'h7777);
    chk1("lim_tmo", bus.timeout_err, 1'b0);
    bus.imem_rd = 0; bus.mem_ready = 0;
    tick;
    // watchdog: data read that never completes
    bus.dmem_req = 1; bus.dmem_rd = 1; bus.dmem_addr = 16'h6000;
    tick;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk1($sformatf("wd_cmp%0d", i), bus.complete_data, 1'b0);
    end
    chk1("wd_b8_en", bus.mem_en, 1'b1);
    tick;
    chk1("wd_cmp", bus.complete_data, 1'b1);
    chk16("wd_dout", bus.data_dout, 16'hFFFF);
    chk1("wd_tmo", bus.timeout_err, 1'b1);
    chk1("wd_en", bus.mem_en, 1'b0);
    bus.dmem_req = 0;
    tick;
    // timeout flag sticks through a normal access
    bus.imem_rd = 1; bus.imem_addr = 16'h3002; bus.mem_ready = 1; bus.mem_dout = 16'h5555;
    tick; tick;
    chk1("st_cmp", bus.complete_instr, 1'b1);
    chk16("st_dout", bus.instr_dout, 16'h5555);
    chk1("st_tmo", bus.timeout_err, 1'b1);
    bus.imem_rd = 0; bus.mem_ready = 0;
    tick;
    // asynchronous reset in the middle of an access
    bus.imem_rd = 1; bus.imem_addr = 16'h3000;
    tick;
    chk1("rb_en", bus.mem_en, 1'b1);
    #2 rst = 1;
    #1;
    chk1("ra_en", bus.mem_en, 1'b0);
    chk1("ra_busy", bus.busy, 1'b0);
    chk1("ra_tmo", bus.timeout_err, 1'b0);
    chk16("ra_idout", bus.instr_dout, 16'h0000);
    tick;
    chk1("ra_cmp", bus.complete_instr, 1'b0);
    rst = 0;
    tick;
    chk1("rg_en", bus.mem_en, 1'b1);
    chk16("rg_addr", bus.mem_addr, 16'h3000);
    bus.mem_ready = 1; bus.mem_dout = 16'h9999;
    tick;
    chk1("rg_cmp", bus.complete_instr, 1'b1);
    chk16("rg_dout", bus.instr_dout, 16'h9999);
    bus.imem_rd = 0; bus.mem_ready = 0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
